spike_renderer: RTL and testbench
=================================

# spike_renderer

Parametrised, pipelined renderer for the spike obstacle layer. For each VGA pixel (DrawX, DrawY) it finds the highest-priority enabled spike covering that pixel and computes the sprite-ROM word address with optional vertical and horizontal flip. It unpacks the 4-bpp texel, maps it through a writable 16-entry palette, and outputs a registered RGB444 colour with an opaque flag, aligned to a fixed latency. It sits between the game-logic object tables and the top-level colour mux, and owns the ROM address/data interface so ROM latency is absorbed internally.

## Interface
- NUM_SPIKES, 24, number of spike objects
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 20, sprite height in pixels
- ROM_LATENCY, 2, cycles from rom_addr to valid rom_data (≥1)
- ADDR_W, 6, ROM word-address width; must satisfy 2^ADDR_W*8 ≥ SPRITE_W*SPRITE_H
- clk_125MHz  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate, new value every cycle
- frame_start  in  1  one-cycle pulse; latches object tables into shadow registers
- SpikeX[0:NUM_SPIKES-1], SpikeY[0:NUM_SPIKES-1]  in  10 each  top-left corner per object
- Spike_Enable[0:NUM_SPIKES-1]  in  1 each  object visible
- Draw_direction[0:NUM_SPIKES-1]  in  1 each  1 = vertical flip (spike points down)
- Spike_Mirror[0:NUM_SPIKES-1]  in  1 each  1 = horizontal flip
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry index
- pal_data  in  12  {R,G,B} 4 bits each
- rom_addr  out  ADDR_W  sprite ROM word address
- rom_data  in  32  sprite ROM word; 8 texels, texel 0 in bits [3:0]
- Spike_Red, Spike_Green, Spike_Blue  out  4 each  pixel colour
- Spike_Hit  out  1  1 = opaque spike pixel at the aligned coordinate

## Operation
- Shadow tables: on frame_start, SpikeX/Y, Spike_Enable, Draw_direction and Spike_Mirror for all objects are copied into shadow registers. All hit detection uses shadow values only, so no mid-frame tearing occurs.
- Hit test (stage 0, combinational on shadow data): object i hits when enabled, SpikeX[i] ≤ DrawX < SpikeX[i]+SPRITE_W, and SpikeY[i] ≤ DrawY < SpikeY[i]+SPRITE_H.
  - Sums are computed in 11 bits; objects near coordinate 1023 never wrap to low coordinates.
  - The lowest index wins among overlapping objects.
- Texel coordinates: dx = DrawX−SpikeX, dy = DrawY−SpikeY.
  - col = mirror ? SPRITE_W−1−dx : dx
  - row = vflip ? SPRITE_H−1−dy : dy
  - p = row*SPRITE_W + col
  - word = p>>3, nibble = p[2:0]
- Stage 0→1: rom_addr ← word on a hit, 0 on a miss. The nibble select and a hit bit enter a delay line of depth ROM_LATENCY.
- Output stage: idx = rom_data[4*nibble +: 4].
  - If the delayed hit is set and idx≠0: colour ← palette[idx], Spike_Hit ← 1.
  - Otherwise colour ← 0 and Spike_Hit ← 0.
  - Index 0 is always transparent.
- Palette: on pal_we, palette[pal_addr] ← pal_data at the clock edge. The output stage reads the palette after the write takes effect (write-first).
- frame_start together with pal_we in the same cycle: both updates take effect.

## Timing
- Latency is ROM_LATENCY+2 cycles (4 by default): the colour for the DrawX/DrawY presented at cycle t appears at t+ROM_LATENCY+2.
- Throughput is one pixel per cycle, with no stalls.
- Shadow update is visible to the DrawX sampled in the cycle after the frame_start edge. Pixels already in the pipeline complete with the old tables.
- Reset (asynchronous assert, synchronous release) clears all of the following to 0:
  - shadow tables, including all enables
  - palette
  - rom_addr
  - delay line
  - Spike_Red/Green/Blue and Spike_Hit
- Until the first frame_start after reset, all objects are disabled and Spike_Hit stays 0.
- Reset asserted mid-frame clears the outputs within the same cycle, regardless of the clock.

## Test plan
- Reset, then palette[5]=12'hF80. Object 0 at (100,50), enabled, no flip; ROM texel p=0 holds 5. Pulse frame_start, drive (100,50) at cycle t → at t+4 Spike_Hit=1, RGB = F,8,0, rom_addr=0 at t+1.
- Same object with Draw_direction=1, drive (100,50) → rom_addr = (19*20)>>3 = 47, nibble = 4. Add Spike_Mirror=1 → p=399, rom_addr=49, nibble=7.
- Objects 3 and 7 both at (200,200) with different textures via flips → colour follows object 3. Disable object 3 → object 7 shown after the next frame_start only.
- Object at X=1015, drive DrawX=2 on the same row → Spike_Hit=0 (no wrap). DrawX=1023 → hit, dx=8.
- Texel index 0 inside the box → Spike_Hit=0, RGB=0. Change SpikeX without frame_start → output unchanged.
- Assert reset_n=0 mid-stream → all outputs 0 immediately. After release without frame_start, a sweep of the full screen gives Spike_Hit=0 everywhere.

Source files
------------

// File: rtl/spike_renderer.sv
// Spike obstacle layer renderer: per-pixel priority hit test on frame-latched object
// tables, sprite ROM fetch with flips, 4-bpp palette lookup, fixed-latency RGB444 output.
module spike_renderer #(
  parameter int unsigned NUM_SPIKES  = 24,
  parameter int unsigned SPRITE_W    = 20,
  parameter int unsigned SPRITE_H    = 20,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk_125MHz,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [9:0]        SpikeX         [NUM_SPIKES],
  input  logic [9:0]        SpikeY         [NUM_SPIKES],
  input  logic              Spike_Enable   [NUM_SPIKES],
  input  logic              Draw_direction [NUM_SPIKES],
  input  logic              Spike_Mirror   [NUM_SPIKES],
  input  logic              pal_we,
  input  logic [3:0]        pal_addr,
  input  logic [11:0]       pal_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [3:0]        Spike_Red,
  output logic [3:0]        Spike_Green,
  output logic [3:0]        Spike_Blue,
  output logic              Spike_Hit
);

  localparam int unsigned PW = ADDR_W + 3;
  localparam int unsigned DL = ROM_LATENCY + 1;

  logic [9:0]            sx_q [NUM_SPIKES];
  logic [9:0]            sy_q [NUM_SPIKES];
  logic [NUM_SPIKES-1:0] en_q, vf_q, mi_q;

  // Shadow object tables, refreshed only at frame start to avoid tearing.
  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
      end
      en_q <= '0;
      vf_q <= '0;
      mi_q <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        sx_q[i] <= SpikeX[i];
        sy_q[i] <= SpikeY[i];
        en_q[i] <= Spike_Enable[i];
        vf_q[i] <= Draw_direction[i];
        mi_q[i] <= Spike_Mirror[i];
      end
    end
  end

  logic          hit_c, vf_c, mi_c;
  logic [9:0]    dx_c, dy_c, col_c, row_c;
  logic [PW-1:0] p_c;
  logic [ADDR_W-1:0] rom_addr_d;

  // Scan downwards so the lowest-index covering object is the one left selected.
  always_comb begin
    hit_c = 1'b0;
    vf_c  = 1'b0;
    mi_c  = 1'b0;
    dx_c  = '0;
    dy_c  = '0;
    for (int i = NUM_SPIKES - 1; i >= 0; i--) begin
      if (en_q[i] &&
          ({1'b0, DrawX} >= {1'b0, sx_q[i]}) &&
          ({1'b0, DrawX} <  {1'b0, sx_q[i]} + 11'(SPRITE_W)) &&
          ({1'b0, DrawY} >= {1'b0, sy_q[i]}) &&
          ({1'b0, DrawY} <  {1'b0, sy_q[i]} + 11'(SPRITE_H))) begin
        hit_c = 1'b1;
        vf_c  = vf_q[i];
        mi_c  = mi_q[i];
        dx_c  = DrawX - sx_q[i];
        dy_c  = DrawY - sy_q[i];
      end
    end
    col_c      = mi_c ? 10'(SPRITE_W - 1) - dx_c : dx_c;
    row_c      = vf_c ? 10'(SPRITE_H - 1) - dy_c : dy_c;
    p_c        = PW'(row_c) * PW'(SPRITE_W) + PW'(col_c);
    rom_addr_d = hit_c ? p_c[PW-1:3] : '0;
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic [DL-1:0]     dhit_q;
  logic [2:0]        dnib_q [DL];

  // ROM address register plus hit/nibble delay matched to the ROM read latency.
  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      dhit_q     <= '0;
      for (int i = 0; i < DL; i++) dnib_q[i] <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      dhit_q     <= {dhit_q[DL-2:0], hit_c};
      dnib_q[0]  <= hit_c ? p_c[2:0] : 3'd0;
      for (int i = 1; i < DL; i++) dnib_q[i] <= dnib_q[i-1];
    end
  end

  logic [11:0] pal_q [16];

  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  logic [3:0]  idx_c;
  logic [11:0] colour_c;
  logic        opaque_c;
  logic [11:0] rgb_d, rgb_q;
  logic        hit_d, hit_q;

  // Same-cycle palette write is forwarded so the output sees the new entry.
  always_comb begin
    idx_c    = rom_data[{dnib_q[DL-1], 2'b00} +: 4];
    colour_c = (pal_we && (pal_addr == idx_c)) ? pal_data : pal_q[idx_c];
    opaque_c = dhit_q[DL-1] && (idx_c != 4'd0);
    rgb_d    = opaque_c ? colour_c : 12'd0;
    hit_d    = opaque_c;
  end

  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign Spike_Red   = rgb_q[11:8];
  assign Spike_Green = rgb_q[7:4];
  assign Spike_Blue  = rgb_q[3:0];
  assign Spike_Hit   = hit_q;

endmodule

// File: tb/tb_spike_renderer.sv
// Randomised and directed bench for spike_renderer against a pixel-rule reference model.
module tb_spike_renderer;

  localparam int NUM = 24;
  localparam int W   = 20;
  localparam int H   = 20;
  localparam int LAT = 2;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0;
  logic          frame_start = 1'b0;
  logic [9:0]    SpikeX [NUM];
  logic [9:0]    SpikeY [NUM];
  logic          Spike_Enable [NUM];
  logic          Draw_direction [NUM];
  logic          Spike_Mirror [NUM];
  logic          pal_we = 1'b0;
  logic [3:0]    pal_addr = '0;
  logic [11:0]   pal_data = '0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic [3:0]    Spike_Red, Spike_Green, Spike_Blue;
  logic          Spike_Hit;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  spike_renderer #(.NUM_SPIKES(NUM), .SPRITE_W(W), .SPRITE_H(H),
                   .ROM_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk_125MHz(clk), .reset_n(rst_n), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .SpikeX(SpikeX), .SpikeY(SpikeY),
    .Spike_Enable(Spike_Enable), .Draw_direction(Draw_direction),
    .Spike_Mirror(Spike_Mirror), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .Spike_Red(Spike_Red), .Spike_Green(Spike_Green), .Spike_Blue(Spike_Blue),
    .Spike_Hit(Spike_Hit));

  always #4 clk = ~clk;

  // Sprite ROM with a fixed read latency.
  logic [31:0] mem [64];
  logic [31:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= mem[rom_addr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame-latched tables, palette and in-flight pixel results.
  int  m_sx [NUM], m_sy [NUM];
  bit  m_en [NUM], m_vf [NUM], m_mi [NUM];
  int  m_pal [16];
  bit  q_hit [$];
  int  q_idx [$];
  int  exp_addr = 0, exp_rgb = 0;
  bit  exp_hit = 0;

  function automatic void lookup(input int x, input int y, output bit h,
                                 output int word, output int nib);
    h = 0; word = 0; nib = 0;
    for (int i = 0; i < NUM; i++) begin
      if (m_en[i] && x >= m_sx[i] && x < m_sx[i] + W && y >= m_sy[i] && y < m_sy[i] + H) begin
        int col, row, p;
        col  = m_mi[i] ? W - 1 - (x - m_sx[i]) : x - m_sx[i];
        row  = m_vf[i] ? H - 1 - (y - m_sy[i]) : y - m_sy[i];
        p    = row * W + col;
        word = p / 8;
        nib  = p % 8;
        h    = 1;
        break;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        m_sx[i] = 0; m_sy[i] = 0; m_en[i] = 0; m_vf[i] = 0; m_mi[i] = 0;
      end
      for (int i = 0; i < 16; i++) m_pal[i] = 0;
      q_hit.delete(); q_idx.delete();
      for (int i = 0; i < LAT + 1; i++) begin q_hit.push_back(0); q_idx.push_back(0); end
      exp_addr = 0; exp_rgb = 0; exp_hit = 0;
    end else begin
      bit h, oh;
      int word, nib, oi;
      if (pal_we) m_pal[pal_addr] = int'(pal_data);
      oh = q_hit.pop_front();
      oi = q_idx.pop_front();
      exp_hit = oh && oi != 0;
      exp_rgb = exp_hit ? m_pal[oi] : 0;
      lookup(int'(DrawX), int'(DrawY), h, word, nib);
      exp_addr = h ? word : 0;
      q_hit.push_back(h);
      q_idx.push_back(h ? int'((mem[word] >> (4 * nib)) & 32'hF) : 0);
      if (frame_start) begin
        for (int i = 0; i < NUM; i++) begin
          m_sx[i] = int'(SpikeX[i]); m_sy[i] = int'(SpikeY[i]);
          m_en[i] = Spike_Enable[i]; m_vf[i] = Draw_direction[i]; m_mi[i] = Spike_Mirror[i];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en)
      check("pixel", {13'd0, Spike_Hit, Spike_Red, Spike_Green, Spike_Blue, rom_addr},
            {13'd0, exp_hit, 12'(exp_rgb), AW'(exp_addr)});
  end

  task automatic frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic pal_write(input int a, input int d);
    @(negedge clk); pal_we = 1'b1; pal_addr = 4'(a); pal_data = 12'(d);
    @(negedge clk); pal_we = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic [AW-1:0] a,
                       output logic h, output logic [11:0] c);
    @(negedge clk); DrawX = 10'(x); DrawY = 10'(y);
    @(negedge clk); a = rom_addr;
    repeat (3) @(negedge clk);
    h = Spike_Hit; c = {Spike_Red, Spike_Green, Spike_Blue};
  endtask

  task automatic set_obj(input int k, input int x, input int y, input bit en,
                         input bit vf, input bit mi);
    SpikeX[k] = 10'(x); SpikeY[k] = 10'(y);
    Spike_Enable[k] = en; Draw_direction[k] = vf; Spike_Mirror[k] = mi;
  endtask

  logic [AW-1:0] a;
  logic          h;
  logic [11:0]   c;
  int            sweep_hits;

  initial begin
    for (int i = 0; i < NUM; i++) set_obj(i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0][3:0] = 4'h5; mem[0][7:4] = 4'h0; mem[1][3:0] = 4'h6;
    mem[47][19:16] = 4'h9; mem[49][31:28] = 4'h3;

    repeat (3) @(negedge clk);
    #1 check("reset_out", {Spike_Hit, Spike_Red, Spike_Green, Spike_Blue, rom_addr}, 0);
    @(negedge clk); rst_n = 1'b1; chk_en = 1;

    for (int i = 1; i < 16; i++) pal_write(i, int'($urandom_range(1, 4095)));
    pal_write(5, 12'hF80);

    set_obj(0, 100, 50, 1, 0, 0);
    probe(100, 50, a, h, c);
    check("pre_frame_hit", {31'd0, h}, 0);
    frame();
    probe(100, 50, a, h, c);
    check("base_addr", {26'd0, a}, 0);
    check("base_hit", {31'd0, h}, 1);
    check("base_rgb", {20'd0, c}, 32'hF80);

    set_obj(0, 100, 50, 1, 1, 0); frame();
    probe(100, 50, a, h, c);
    check("vflip_addr", {26'd0, a}, 47);
    set_obj(0, 100, 50, 1, 1, 1); frame();
    probe(100, 50, a, h, c);
    check("vhflip_addr", {26'd0, a}, 49);

    set_obj(0, 100, 50, 0, 0, 0);
    set_obj(3, 200, 200, 1, 0, 0);
    set_obj(7, 200, 200, 1, 1, 0); frame();
    probe(200, 200, a, h, c);
    check("prio_addr", {26'd0, a}, 0);
    check("prio_rgb", {20'd0, c}, 32'hF80);
    set_obj(3, 200, 200, 0, 0, 0);
    probe(200, 200, a, h, c);
    check("nofs_addr", {26'd0, a}, 0);
    frame();
    probe(200, 200, a, h, c);
    check("obj7_addr", {26'd0, a}, 47);

    set_obj(0, 100, 50, 1, 0, 0);
    set_obj(1, 1015, 300, 1, 0, 0); frame();
    probe(2, 300, a, h, c);
    check("nowrap_hit", {31'd0, h}, 0);
    probe(1023, 300, a, h, c);
    check("edge_addr", {26'd0, a}, 1);
    check("edge_hit", {31'd0, h}, 1);
    probe(101, 50, a, h, c);
    check("transp_hit", {31'd0, h}, 0);
    check("transp_rgb", {20'd0, c}, 0);
    set_obj(0, 500, 50, 1, 0, 0);
    probe(100, 50, a, h, c);
    check("stale_hit", {31'd0, h}, 1);

    // Random phase: table changes mostly coincide with frame_start.
    for (int n = 0; n < 3000; n++) begin
      int k;
      @(negedge clk);
      frame_start = ($urandom_range(0, 11) == 0);
      if (frame_start || $urandom_range(0, 31) == 0)
        for (int i = 0; i < NUM; i++)
          set_obj(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(995, 1023))
                                                : int'($urandom_range(0, 660)),
                  int'($urandom_range(0, 480)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pal_we   = ($urandom_range(0, 3) == 0);
      pal_addr = 4'($urandom);
      pal_data = 12'($urandom);
      k = int'($urandom_range(0, NUM - 1));
      if ($urandom_range(0, 7) == 0) begin
        DrawX = 10'($urandom); DrawY = 10'($urandom);
      end else begin
        DrawX = 10'(int'(SpikeX[k]) + int'($urandom_range(0, 27)) - 4);
        DrawY = 10'(int'(SpikeY[k]) + int'($urandom_range(0, 27)) - 4);
      end
    end
    @(negedge clk); frame_start = 1'b0; pal_we = 1'b0;

    for (int i = 0; i < NUM; i++) set_obj(i, 20 * i, 20 * i, 1, 0, 0);
    set_obj(0, 100, 50, 1, 0, 0);
    pal_write(5, 12'hF80);
    frame();
    @(negedge clk); DrawX = 10'd100; DrawY = 10'd50;
    repeat (6) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset", {Spike_Hit, Spike_Red, Spike_Green, Spike_Blue, rom_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sweep_hits = 0;
    for (int y = 0; y < 480; y += 5)
      for (int x = 0; x < 640; x += 5) begin
        @(negedge clk); DrawX = 10'(x); DrawY = 10'(y);
        if (Spike_Hit) sweep_hits++;
      end
    repeat (6) @(negedge clk);
    check("sweep_hits", 32'(sweep_hits), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
